// File: rtl/demux_deser_if.sv
// Bus between the serial-path driver and the 1-to-N deserialiser:
// control/data inputs toward the demux, registered word and status back.
interface demux_deser_if #(
  parameter int SELBITS_DEMUX  = 3,
  parameter int NOUTPUTS_DEMUX = 8
);
  logic                      clear;
  logic                      load;
  logic                      autoMode;
  logic [SELBITS_DEMUX-1:0]  Select;
  logic                      dataInput;
  logic [NOUTPUTS_DEMUX-1:0] dataOutput;
  logic                      wordValid;
  logic                      busy;

  modport master (
    output clear, load, autoMode, Select, dataInput,
    input  dataOutput, wordValid, busy
  );

  modport slave (
    input  clear, load, autoMode, Select, dataInput,
    output dataOutput, wordValid, busy
  );
endinterface

// File: rtl/demux_deser.sv
// Registered 1-to-N demux: routes one bit per load into an N-bit word, either at Select
// (direct) or via an auto-increment pointer that deserialises a word and pulses wordValid.
module demux_deser #(
  parameter int SELBITS_DEMUX  = 3,
  parameter int NOUTPUTS_DEMUX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_deser_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SELBITS_DEMUX-1:0] LAST_IDX = SELBITS_DEMUX'(NOUTPUTS_DEMUX - 1);
  localparam logic [SELBITS_DEMUX-1:0] ONE_IDX  = SELBITS_DEMUX'(1);

  state_t                    state_q;
  logic [SELBITS_DEMUX-1:0]  ptr_q;
  logic [NOUTPUTS_DEMUX-1:0] data_q;
  logic                      valid_q;
  logic                      busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        data_q  <= '0;
        busy_q  <= 1'b0;
      end else if (bus.load) begin
        case (state_q)
          IDLE: begin
            if (bus.autoMode) begin
              // A new auto word wipes stale bits from earlier direct writes.
              data_q    <= '0;
              data_q[0] <= bus.dataInput;
              if (NOUTPUTS_DEMUX == 1) begin
                valid_q <= 1'b1;
              end else begin
                ptr_q   <= ONE_IDX;
                state_q <= SHIFT;
                busy_q  <= 1'b1;
              end
            end else if (int'(bus.Select) < NOUTPUTS_DEMUX) begin
              data_q[bus.Select] <= bus.dataInput;
            end
          end
          SHIFT: begin
            data_q[ptr_q] <= bus.dataInput;
            if (ptr_q == LAST_IDX) begin
              ptr_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + ONE_IDX;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.dataOutput = data_q;
  assign bus.wordValid  = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_demux_deser.sv
// Directed + randomized bench for demux_deser against a queue-based reference model.
module tb_demux_deser;

  localparam int SB = 3;
  localparam int N  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  demux_deser_if #(.SELBITS_DEMUX(SB), .NOUTPUTS_DEMUX(N)) bus ();

  demux_deser #(.SELBITS_DEMUX(SB), .NOUTPUTS_DEMUX(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the word under construction is just the list of bits received so far.
  logic [N-1:0] m_word;
  logic         m_valid;
  bit           m_bits[$];
  int           pulses[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word  = '0;
    m_valid = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_edge(input logic c, input logic l, input logic a,
                            input logic [SB-1:0] s, input logic d);
    m_valid = 1'b0;
    if (c) begin
      model_reset();
    end else if (l) begin
      if (m_bits.size() == 0 && !a) begin
        if (int'(s) < N) m_word[s] = d;
      end else begin
        m_bits.push_back(d);
        m_word = '0;
        foreach (m_bits[i]) m_word[i] = m_bits[i];
        if (m_bits.size() == N) begin
          m_valid = 1'b1;
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  32'(bus.dataOutput), 32'(m_word));
    chk({tag, ".valid"}, 32'(bus.wordValid),  32'(m_valid));
    chk({tag, ".busy"},  32'(bus.busy),       32'(m_bits.size() != 0));
  endtask

  task automatic step(input string tag, input logic c, input logic l, input logic a,
                      input logic [SB-1:0] s, input logic d);
    bus.clear     = c;
    bus.load      = l;
    bus.autoMode  = a;
    bus.Select    = s;
    bus.dataInput = d;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(c, l, a, s, d);
    if (bus.wordValid === 1'b1) pulses.push_back(cyc);
    check_all(tag);
  endtask

  task automatic auto_word(input string tag, input logic [N-1:0] w);
    for (int i = 0; i < N; i++) step(tag, 1'b0, 1'b1, 1'b1, SB'($urandom), w[i]);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    cyc++;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    bus.clear = 1'b0; bus.load = 1'b0; bus.autoMode = 1'b0;
    bus.Select = '0;  bus.dataInput = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_all("reset");
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Direct mode fill then clear bit 3
    for (int i = 0; i < N; i++) step("direct", 1'b0, 1'b1, 1'b0, SB'(i), 1'b1);
    chk("direct.full", 32'(bus.dataOutput), 32'h0000_00FF);
    step("direct3", 1'b0, 1'b1, 1'b0, SB'(3), 1'b0);
    chk("direct.f7", 32'(bus.dataOutput), 32'h0000_00F7);

    // Async reset mid-clock with non-zero contents
    async_reset("arst1");

    // Auto word A5
    pulses.delete();
    auto_word("autoA5", 8'hA5);
    chk("autoA5.word",  32'(bus.dataOutput), 32'h0000_00A5);
    chk("autoA5.pulse", 32'(bus.wordValid), 32'd1);
    step("autoA5.after", 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("autoA5.npulse", 32'(pulses.size()), 32'd1);

    // Stall after bit 3 with autoMode/Select toggling
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b1, '0, 1'(8'h3C >> i));
    for (int i = 0; i < 5; i++)
      step("stall.hold", 1'b0, 1'b0, 1'($urandom), SB'($urandom), 1'($urandom));
    for (int i = 3; i < N; i++)
      step("stall.rest", 1'b0, 1'b1, 1'($urandom), SB'($urandom), 1'(8'h3C >> i));
    chk("stall.word", 32'(bus.dataOutput), 32'h0000_003C);

    // Back-to-back words
    pulses.delete();
    auto_word("b2b.c3", 8'hC3);
    chk("b2b.c3.word", 32'(bus.dataOutput), 32'h0000_00C3);
    auto_word("b2b.5a", 8'h5A);
    chk("b2b.5a.word", 32'(bus.dataOutput), 32'h0000_005A);
    chk("b2b.npulse", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) chk("b2b.gap", 32'(pulses[1] - pulses[0]), 32'd8);

    // Interruption by clear, then by async reset
    pulses.delete();
    for (int i = 0; i < 4; i++) step("intr.c", 1'b0, 1'b1, 1'b1, '0, 1'b1);
    step("intr.clear", 1'b1, 1'b1, 1'b1, '0, 1'b1);
    chk("intr.clear.data", 32'(bus.dataOutput), 32'd0);
    for (int i = 0; i < 4; i++) step("intr.r", 1'b0, 1'b1, 1'b1, '0, 1'b1);
    async_reset("intr.arst");
    step("intr.post", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("intr.nopulse", 32'(pulses.size()), 32'd0);
    auto_word("intr.next", 8'h96);
    chk("intr.next.word", 32'(bus.dataOutput), 32'h0000_0096);

    // Randomized mix
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), SB'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
